typewriter_ctrl: RTL and testbench
==================================

# typewriter_ctrl

Key-event sequencer and display scan controller for the typewriter. It turns raw key events into a 4-glyph text buffer with cursor, backspace and clear. It also time-multiplexes that buffer onto one shared digit-code bus with active-low anode enables, so a single segment decoder drives all four 7-segment positions. It sits between the keypad front end and the segment decoder, and exposes the full buffer in parallel for the per-digit decoder path.

## Interface
- SCAN_DIV, 50000: clock cycles each digit position is owned by the shared bus; must be ≥ 2.
- BLANK_CYCLES, 4: cycles at the start of each digit slot with all anodes off (anti-ghosting); must satisfy 0 ≤ BLANK_CYCLES < SCAN_DIV.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_code  in  5  key value; 0–15 glyph, 16 backspace, 17 clear, 18–31 ignored.
- key_pressed  in  1  level, synchronous to clk; an event is its 0→1 transition.
- digits_out  out  16  buffer contents, slot i at bits [4i+3:4i]; slot 0 oldest/leftmost.
- digit_code  out  4  glyph of currently scanned position.
- an_n  out  4  active-low anode enables, one-hot-low or all high.
- char_count  out  3  number of valid glyphs, 0–4.
- key_accept  out  1  one-cycle pulse when an event changed the buffer.

## Operation
- Blank glyph is 4'hF; unused slots always hold 4'hF.
- Edge detect: register prev of key_pressed. An event occurs at a posedge where key_pressed=1 and prev=0. Holding the key generates no further events.
- Glyph event (code 0–15), count < 4: slot[count] ← code[3:0]; count+1.
- Glyph event, count = 4: slot0←slot1, slot1←slot2, slot2←slot3, slot3←code[3:0]; count stays 4.
- Backspace, count > 0: slot[count-1] ← F; count−1. Backspace at count = 0: no change, no key_accept.
- Clear: all slots ← F, count ← 0. key_accept asserts if count was > 0; otherwise no pulse.
- Codes 18–31: edge is consumed (prev updates), buffer unchanged, no key_accept.
- Scan FSM, two states per digit slot:
  - BLANK: cycles 0..BLANK_CYCLES-1 of the slot; an_n = 4'b1111.
  - DRIVE: remaining cycles; an_n[idx] = 0, others 1.
- Slot counter runs 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and idx advances 0→1→2→3→0. If BLANK_CYCLES = 0, BLANK is skipped.
- digit_code = slot[idx] at all times, including during BLANK.
- Scan runs continuously and independently of key events.

## Timing
- Reset (async assert): all slots F, digits_out 16'hFFFF, char_count 0, prev 0, key_accept 0, idx 0, slot counter 0, digit_code F.
  - an_n is 4'b1111 during reset.
  - After release, an_n follows the FSM. When BLANK_CYCLES = 0, an_n is 4'b1110 on the first cycle after release.
- Key latency: digits_out, char_count and key_accept update on the same posedge that first samples key_pressed=1. They are visible 1 cycle after key_pressed rises. key_accept is high for exactly that one cycle.
- A key buffer update in the middle of a slot takes effect on digit_code in the next cycle. The slot timing is not disturbed.
- key_pressed high at reset release: prev=0, so one event fires on the first clock edge.
- Reset asserted mid-slot or mid-event: everything returns to reset values immediately; no partial buffer update survives.

## Test plan
- SCAN_DIV=8, BLANK_CYCLES=2, reset release, no keys:
  - an_n = 1111 for 2 cycles, then 1110 for 6, then 1111 ×2, then 1101 ×6, …, wrapping back to idx 0 after 32 cycles.
  - digit_code = F throughout.
- Type 1,2,3 (pulses ≥1 cycle apart, low between):
  - digits_out = 16'hF321, char_count = 3.
  - key_accept pulses 3 times, each 1 cycle after a rise.
- Type 1,2,3,4,5:
  - digits_out = 16'h5432, char_count = 4.
  - Then hold key_pressed high for 20 cycles: no change, no extra key_accept.
- From 16'hF321: backspace → 16'hFF21, count 2.
  - Backspace ×2 → 16'hFFFF, count 0.
  - A further backspace → no change, key_accept stays 0.
- From 16'h5432: clear (17) → 16'hFFFF, count 0, one key_accept. Code 25 → no change, no key_accept.
- Async reset mid-scan (idx=2) with count=3: outputs go to reset values without a clock edge. Scan restarts at idx 0 after release.

Source files
------------

// File: rtl/typewriter_ctrl_if.sv
// Key-event and display-scan signal bundle between the keypad front end,
// typewriter_ctrl and the shared segment decoder.
interface typewriter_ctrl_if;
  logic [4:0]  key_code;
  logic        key_pressed;
  logic [15:0] digits_out;
  logic [3:0]  digit_code;
  logic [3:0]  an_n;
  logic [2:0]  char_count;
  logic        key_accept;

  modport master (
    output key_code, key_pressed,
    input  digits_out, digit_code, an_n, char_count, key_accept
  );

  modport slave (
    input  key_code, key_pressed,
    output digits_out, digit_code, an_n, char_count, key_accept
  );
endinterface

// File: rtl/typewriter_ctrl.sv
// Typewriter key sequencer (4-glyph buffer, backspace, clear) plus a
// time-multiplexed scan of that buffer onto one digit-code bus.
//
// state   | meaning
// S_BLANK | first BLANK_CYCLES of a digit slot, all anodes off
// S_DRIVE | rest of the slot, anode of position idx enabled
module typewriter_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  typewriter_ctrl_if.slave  bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_W  = CW'(BLANK_CYCLES);

  typedef enum logic {S_BLANK, S_DRIVE} scan_state_t;
  localparam scan_state_t S_INIT = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;

  logic [3:0]  slot [4];
  logic [2:0]  count;
  logic        prev;
  logic        accept;
  logic        event_hit;
  logic [1:0]  bs_idx;

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  scan_state_t   state, state_nxt;

  assign event_hit = bus.key_pressed & ~prev;
  assign bs_idx    = 2'(count - 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) slot[i] <= 4'hF;
      count  <= 3'd0;
      prev   <= 1'b0;
      accept <= 1'b0;
    end else begin
      prev   <= bus.key_pressed;
      accept <= 1'b0;
      if (event_hit) begin
        if (bus.key_code < 5'd16) begin
          accept <= 1'b1;
          if (count == 3'd4) begin
            // Full buffer scrolls left; the newest glyph lands at the right.
            slot[0] <= slot[1];
            slot[1] <= slot[2];
            slot[2] <= slot[3];
            slot[3] <= bus.key_code[3:0];
          end else begin
            slot[count[1:0]] <= bus.key_code[3:0];
            count            <= count + 3'd1;
          end
        end else if (bus.key_code == 5'd16) begin
          if (count != 3'd0) begin
            slot[bs_idx] <= 4'hF;
            count        <= count - 3'd1;
            accept       <= 1'b1;
          end
        end else if (bus.key_code == 5'd17) begin
          for (int i = 0; i < 4; i++) slot[i] <= 4'hF;
          count  <= 3'd0;
          accept <= (count != 3'd0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= 2'd0;
      state <= S_INIT;
    end else begin
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      state <= state_nxt;
    end
  end

  always_comb begin
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    state_nxt = state;
    if (cnt == LAST_CNT) begin
      cnt_nxt = '0;
      idx_nxt = idx + 2'd1;
    end
    state_nxt = (cnt_nxt < BLANK_W) ? S_BLANK : S_DRIVE;
  end

  // Reset gating keeps the anodes dark while rst_n is low even when the
  // reset state is S_DRIVE (zero blanking).
  always_comb begin
    bus.an_n = 4'b1111;
    if (state == S_DRIVE && rst_n) bus.an_n[idx] = 1'b0;
  end

  assign bus.digit_code = slot[idx];
  assign bus.digits_out = {slot[3], slot[2], slot[1], slot[0]};
  assign bus.char_count = count;
  assign bus.key_accept = accept;

endmodule

// File: tb/tb_typewriter_ctrl.sv
// Self-checking bench for typewriter_ctrl with a short scan period.
module tb_typewriter_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typewriter_ctrl_if bus ();

  typewriter_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  code;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        accept;
  } vec_t;

  typedef struct {
    logic [15:0] digits;
    logic [2:0]  count;
    logic        accept;
  } exp_t;

  vec_t tbl [20];
  exp_t sb [$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_scan(input int n, input logic [3:0] code_exp);
    for (int k = 0; k < n; k++) begin
      logic [3:0] an_exp;
      an_exp = 4'b1111;
      if ((k % SD) >= BC) an_exp[(k / SD) % 4] = 1'b0;
      chk("an_n", {12'd0, bus.an_n}, {12'd0, an_exp});
      chk("scan_digit_code", {12'd0, bus.digit_code}, {12'd0, code_exp});
      @(negedge clk);
    end
  endtask

  task automatic type_key(input logic [4:0] code);
    @(negedge clk);
    bus.key_code = code;
    bus.key_pressed = 1'b1;
    @(negedge clk);
    bus.key_pressed = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_digits", bus.digits_out, 16'hFFFF);
    chk("rst_count", {13'd0, bus.char_count}, 16'd0);
    chk("rst_accept", {15'd0, bus.key_accept}, 16'd0);
    chk("rst_an_n", {12'd0, bus.an_n}, 16'h000F);
    chk("rst_digit_code", {12'd0, bus.digit_code}, 16'h000F);
  endtask

  task automatic wait_anode(input logic [3:0] pat);
    int t;
    t = 0;
    while (bus.an_n !== pat && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (bus.an_n !== pat) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_anode: timeout waiting for an_n=%b", pat);
    end
  endtask

  initial begin
    tbl[0]  = '{5'd1,  16'hFFF1, 3'd1, 1'b1};
    tbl[1]  = '{5'd2,  16'hFF21, 3'd2, 1'b1};
    tbl[2]  = '{5'd3,  16'hF321, 3'd3, 1'b1};
    tbl[3]  = '{5'd16, 16'hFF21, 3'd2, 1'b1};
    tbl[4]  = '{5'd16, 16'hFFF1, 3'd1, 1'b1};
    tbl[5]  = '{5'd16, 16'hFFFF, 3'd0, 1'b1};
    tbl[6]  = '{5'd16, 16'hFFFF, 3'd0, 1'b0};
    tbl[7]  = '{5'd1,  16'hFFF1, 3'd1, 1'b1};
    tbl[8]  = '{5'd2,  16'hFF21, 3'd2, 1'b1};
    tbl[9]  = '{5'd3,  16'hF321, 3'd3, 1'b1};
    tbl[10] = '{5'd4,  16'h4321, 3'd4, 1'b1};
    tbl[11] = '{5'd5,  16'h5432, 3'd4, 1'b1};
    tbl[12] = '{5'd25, 16'h5432, 3'd4, 1'b0};
    tbl[13] = '{5'd17, 16'hFFFF, 3'd0, 1'b1};
    tbl[14] = '{5'd25, 16'hFFFF, 3'd0, 1'b0};
    tbl[15] = '{5'd17, 16'hFFFF, 3'd0, 1'b0};
    tbl[16] = '{5'd0,  16'hFFF0, 3'd1, 1'b1};
    tbl[17] = '{5'd16, 16'hFFFF, 3'd0, 1'b1};
    tbl[18] = '{5'd31, 16'hFFFF, 3'd0, 1'b0};
    tbl[19] = '{5'd10, 16'hFFFA, 3'd1, 1'b1};

    bus.key_code = 5'd0;
    bus.key_pressed = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_scan(40, 4'hF);

    foreach (tbl[i]) begin
      @(negedge clk);
      bus.key_code = tbl[i].code;
      bus.key_pressed = 1'b1;
      sb.push_back('{tbl[i].digits, tbl[i].count, tbl[i].accept});
      @(negedge clk);
      begin
        exp_t e;
        e = sb.pop_front();
        chk("vec_digits", bus.digits_out, e.digits);
        chk("vec_count", {13'd0, bus.char_count}, {13'd0, e.count});
        chk("vec_accept", {15'd0, bus.key_accept}, {15'd0, e.accept});
      end
      bus.key_pressed = 1'b0;
      @(negedge clk);
      chk("accept_width", {15'd0, bus.key_accept}, 16'd0);
    end

    // Holding a key produces a single event.
    @(negedge clk);
    bus.key_code = 5'd7;
    bus.key_pressed = 1'b1;
    @(negedge clk);
    chk("hold_first_digits", bus.digits_out, 16'hFF7A);
    chk("hold_first_accept", {15'd0, bus.key_accept}, 16'd1);
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      chk("hold_accept", {15'd0, bus.key_accept}, 16'd0);
      chk("hold_digits", bus.digits_out, 16'hFF7A);
    end
    bus.key_pressed = 1'b0;

    // Buffer contents reach the scanned bus at the matching position.
    type_key(5'd17);
    type_key(5'd1);
    type_key(5'd2);
    type_key(5'd3);
    @(negedge clk);
    chk("pre_rst_digits", bus.digits_out, 16'hF321);
    chk("pre_rst_count", {13'd0, bus.char_count}, 16'd3);
    wait_anode(4'b1110);
    chk("scan_idx0_code", {12'd0, bus.digit_code}, 16'h0001);
    wait_anode(4'b1011);
    chk("scan_idx2_code", {12'd0, bus.digit_code}, 16'h0003);

    // Async reset mid-slot with no clock edge in between.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_scan(32, 4'hF);

    // Key already held at reset release fires exactly one event.
    @(negedge clk);
    rst_n = 1'b0;
    bus.key_code = 5'd9;
    bus.key_pressed = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_digits", bus.digits_out, 16'hFFF9);
    chk("rel_count", {13'd0, bus.char_count}, 16'd1);
    chk("rel_accept", {15'd0, bus.key_accept}, 16'd1);
    @(negedge clk);
    chk("rel_accept_off", {15'd0, bus.key_accept}, 16'd0);
    bus.key_pressed = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
